// File: rtl/reg_bank.sv
// reg_bank: nlp16af architectural register file (15 stored entries, ZR reads 0) with IP/SP/FLAG side ports.
// Define REG_BANK_BYPASS_EN to forward same-cycle general writes to rd_data and flag_in to flag_true.
module reg_bank #(
    parameter int                DATA_W   = 16,
    parameter int                N_RD     = 2,
    parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] IP_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_RD*4-1:0]        rd_id,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [3:0]               wr_id,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     ip_inc,
    input  logic                     sp_dec,
    input  logic                     sp_inc,
    input  logic                     flag_we,
    input  logic [3:0]               flag_in,
    input  logic [2:0]               flag_sel,
    output logic                     flag_true,
    output logic [DATA_W-1:0]        ip_q,
    output logic [DATA_W-1:0]        sp_q
);
    localparam int FLAG = 4;
    localparam int IP   = 13;
    localparam int SP   = 14;
    localparam logic [3:0] ZR = 4'hF;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] r_regs [15];
    logic [DATA_W-1:0] w_next [15];
    logic [DATA_W-1:0] w_view [16];
    logic [3:0]        w_flags;

    // General write wins over the dedicated step/flag ports on the same register
    always_comb begin
        for (int i = 0; i < 15; i++)
            w_next[i] = (wr_en && wr_id == 4'(i)) ? wr_data : r_regs[i];
        if (!(wr_en && wr_id == 4'(IP)) && ip_inc)
            w_next[IP] = r_regs[IP] + ONE;
        if (!(wr_en && wr_id == 4'(SP)) && (sp_inc ^ sp_dec))
            w_next[SP] = sp_inc ? r_regs[SP] + ONE : r_regs[SP] - ONE;
        if (!(wr_en && wr_id == 4'(FLAG)) && flag_we)
            w_next[FLAG][3:0] = flag_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                r_regs[i] <= (i == IP) ? IP_RESET : (i == SP) ? SP_RESET : '0;
        end else begin
            for (int i = 0; i < 15; i++)
                r_regs[i] <= w_next[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 15; i++)
            w_view[i] = r_regs[i];
        w_view[15] = '0;
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_RD; k++) begin
`ifdef REG_BANK_BYPASS_EN
            rd_data[DATA_W*k +: DATA_W] = (wr_en && wr_id != ZR && rd_id[4*k +: 4] == wr_id)
                                        ? wr_data : w_view[rd_id[4*k +: 4]];
`else
            rd_data[DATA_W*k +: DATA_W] = w_view[rd_id[4*k +: 4]];
`endif
        end
    end

    always_comb begin
        w_flags = r_regs[FLAG][3:0];
`ifdef REG_BANK_BYPASS_EN
        if (flag_we && !(wr_en && wr_id == 4'(FLAG)))
            w_flags = flag_in;
`endif
        flag_true = (flag_sel == 3'd0) ? 1'b1 : flag_sel[2] ? w_flags[flag_sel[1:0]] : 1'b0;
    end

    assign ip_q = r_regs[IP];
    assign sp_q = r_regs[SP];
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed vector table, reset/bypass sequences and randomized checks of reg_bank
// against a behavioural register-array model.
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rd_id = '0;
    logic [31:0] rd_data;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_id = '0;
    logic [15:0] wr_data = '0;
    logic        ip_inc = 1'b0, sp_dec = 1'b0, sp_inc = 1'b0, flag_we = 1'b0;
    logic [3:0]  flag_in = '0;
    logic [2:0]  flag_sel = '0;
    logic        flag_true;
    logic [15:0] ip_q, sp_q;

    int checks = 0;
    int failures = 0;
    logic [15:0] m [16];

    always #5 clk = ~clk;

    reg_bank #(.DATA_W(16), .N_RD(2)) dut (
        .clk(clk), .rst_n(rst_n), .rd_id(rd_id), .rd_data(rd_data),
        .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
        .ip_inc(ip_inc), .sp_dec(sp_dec), .sp_inc(sp_inc),
        .flag_we(flag_we), .flag_in(flag_in), .flag_sel(flag_sel),
        .flag_true(flag_true), .ip_q(ip_q), .sp_q(sp_q)
    );

    typedef struct {
        logic        we;  logic [3:0] wid; logic [15:0] wd;
        logic        ii;  logic sd; logic si; logic fw; logic [3:0] fi;
        logic [2:0]  sel; logic [3:0] r0; logic [3:0] r1;
        logic [15:0] e0;  logic [15:0] e1; logic [15:0] eip; logic [15:0] esp; logic eft;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 16'h0000;
        m[14] = 16'hFFFF;
    endtask

    function automatic logic [15:0] exp_rd(input logic [3:0] id);
        if (id == 4'hF) return 16'h0000;
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && wr_id == id) return wr_data;
`endif
        return m[id];
    endfunction

    function automatic logic exp_ft();
        logic [3:0] f;
        f = m[4][3:0];
`ifdef REG_BANK_BYPASS_EN
        if (flag_we && !(wr_en && wr_id == 4'd4)) f = flag_in;
`endif
        if (flag_sel == 3'd0) return 1'b1;
        if (flag_sel >= 3'd4) return f[flag_sel - 3'd4];
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_rd0"}, rd_data[15:0], exp_rd(rd_id[3:0]));
        chk({tag, "_rd1"}, rd_data[31:16], exp_rd(rd_id[7:4]));
        chk({tag, "_ip"}, ip_q, m[13]);
        chk({tag, "_sp"}, sp_q, m[14]);
        chk({tag, "_ft"}, flag_true, exp_ft());
    endtask

    task automatic tick();
        logic [15:0] n [16];
        @(posedge clk);
        n = m;
        if (wr_en && wr_id != 4'hF) n[wr_id] = wr_data;
        if (!(wr_en && wr_id == 4'd13) && ip_inc) n[13] = m[13] + 16'd1;
        if (!(wr_en && wr_id == 4'd14)) n[14] = m[14] + 16'(sp_inc) - 16'(sp_dec);
        if (!(wr_en && wr_id == 4'd4) && flag_we) n[4][3:0] = flag_in;
        m = n;
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; ip_inc = 1'b0; sp_dec = 1'b0; sp_inc = 1'b0; flag_we = 1'b0;
    endtask

    vec_t vt [18];

    initial begin
        model_reset();
        #2;
        // Reset state
        for (int i = 5; i <= 10; i++) begin
            rd_id = {4'hF, 4'(i)};
            #1;
            chk($sformatf("rst_reg%0d", i), rd_data[15:0], 16'h0000);
            chk($sformatf("rst_zr%0d", i), rd_data[31:16], 16'h0000);
        end
        chk("rst_ip", ip_q, 16'h0000);
        chk("rst_sp", sp_q, 16'hFFFF);
        flag_sel = 3'd0; #1; chk("rst_ft_sel0", flag_true, 1'b1);
        flag_sel = 3'd6; #1; chk("rst_ft_sel6", flag_true, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //       we   wid    wd        ii   sd   si   fw   fi     sel  r0     r1     e0          e1          eip         esp         eft
        vt[0]  = '{1'b1, 4'd5,  16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 4'd5,  4'hF,  16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 1'b1};
        vt[1]  = '{1'b1, 4'hF,  16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 4'hF,  4'd5,  16'h0000, 16'h1234, 16'h0000, 16'hFFFF, 1'b1};
        vt[2]  = '{1'b1, 4'd13, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 4'd13, 4'd14, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
        vt[3]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 4'd13, 4'd14, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};
        vt[4]  = '{1'b1, 4'd14, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 4'd13, 4'd14, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vt[5]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 4'd13, 4'd14, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};
        vt[6]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 4'd13, 4'd14, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};
        vt[7]  = '{1'b1, 4'd13, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 4'd13, 4'd14, 16'h0100, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b1};
        vt[8]  = '{1'b1, 4'd4,  16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 3'd4, 4'd4,  4'hF,  16'h0001, 16'h0000, 16'h0100, 16'hFFFF, 1'b1};
        vt[9]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 3'd0, 4'd4,  4'hF,  16'h0004, 16'h0000, 16'h0100, 16'hFFFF, 1'b1};
        vt[10] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd4, 4'd4,  4'hF,  16'h0004, 16'h0000, 16'h0100, 16'hFFFF, 1'b0};
        vt[11] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd5, 4'd4,  4'hF,  16'h0004, 16'h0000, 16'h0100, 16'hFFFF, 1'b0};
        vt[12] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd6, 4'd4,  4'hF,  16'h0004, 16'h0000, 16'h0100, 16'hFFFF, 1'b1};
        vt[13] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd7, 4'd4,  4'hF,  16'h0004, 16'h0000, 16'h0100, 16'hFFFF, 1'b0};
        vt[14] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd2, 4'd4,  4'hF,  16'h0004, 16'h0000, 16'h0100, 16'hFFFF, 1'b0};
        vt[15] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 4'd14, 4'd5,  16'h0000, 16'h1234, 16'h0100, 16'h0000, 1'b1};
        vt[16] = '{1'b1, 4'd6,  16'h55AA, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 4'd6,  4'd5,  16'h55AA, 16'h1234, 16'h0100, 16'h0000, 1'b1};
        vt[17] = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 4'd13, 4'd14, 16'h0101, 16'hFFFF, 16'h0101, 16'hFFFF, 1'b1};

        for (int v = 0; v < 18; v++) begin
            wr_en = vt[v].we; wr_id = vt[v].wid; wr_data = vt[v].wd;
            ip_inc = vt[v].ii; sp_dec = vt[v].sd; sp_inc = vt[v].si;
            flag_we = vt[v].fw; flag_in = vt[v].fi;
            tick();
            idle();
            rd_id = {vt[v].r1, vt[v].r0};
            flag_sel = vt[v].sel;
            #1;
            chk($sformatf("vec%0d_rd0", v), rd_data[15:0], vt[v].e0);
            chk($sformatf("vec%0d_rd1", v), rd_data[31:16], vt[v].e1);
            chk($sformatf("vec%0d_ip", v), ip_q, vt[v].eip);
            chk($sformatf("vec%0d_sp", v), sp_q, vt[v].esp);
            chk($sformatf("vec%0d_ft", v), flag_true, vt[v].eft);
        end

        // Same-cycle write of B: forwarded only with bypass
        rd_id = {4'hF, 4'd6};
        wr_en = 1'b1; wr_id = 4'd6; wr_data = 16'h1111;
        #1;
`ifdef REG_BANK_BYPASS_EN
        chk("byp_rd_b", rd_data[15:0], 16'h1111);
`else
        chk("byp_rd_b", rd_data[15:0], 16'h55AA);
`endif
        wr_en = 1'b0; flag_we = 1'b1; flag_in = 4'b1000; flag_sel = 3'd7;
        #1;
`ifdef REG_BANK_BYPASS_EN
        chk("byp_ft", flag_true, 1'b1);
`else
        chk("byp_ft", flag_true, 1'b0);
`endif
        idle();
        @(posedge clk); #1;
        chk("byp_hold_b", rd_data[15:0], 16'h55AA);

        // Reset asserted during a pending write drops it
        wr_en = 1'b1; wr_id = 4'd6; wr_data = 16'h2222; ip_inc = 1'b1; sp_dec = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        idle();
        model_reset();
        #1;
        chk("rst_mid_b", rd_data[15:0], 16'h0000);
        chk("rst_mid_ip", ip_q, 16'h0000);
        chk("rst_mid_sp", sp_q, 16'hFFFF);
        flag_sel = 3'd0; #1; chk("rst_mid_ft0", flag_true, 1'b1);
        flag_sel = 3'd6; #1; chk("rst_mid_ft6", flag_true, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_id   = 4'($urandom_range(0, 15));
            wr_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            ip_inc  = ($urandom_range(0, 3) == 0);
            sp_dec  = ($urandom_range(0, 3) == 0);
            sp_inc  = ($urandom_range(0, 3) == 0);
            flag_we = ($urandom_range(0, 3) == 0);
            flag_in = 4'($urandom);
            flag_sel = 3'($urandom);
            rd_id   = 8'($urandom);
            #1;
            check_all($sformatf("rnd%0d", n));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
